// File: rtl/entity_pkg.sv
// Shared opcode, direction and life-state encodings for the game-entity controller.
package entity_pkg;

   localparam logic [3:0] OP_HEAL    = 4'h1;
   localparam logic [3:0] OP_DAMAGE  = 4'h2;
   localparam logic [3:0] OP_ATK_ADD = 4'h3;
   localparam logic [3:0] OP_ATK_SET = 4'h4;
   localparam logic [3:0] OP_MOVE    = 4'h5;
   localparam logic [3:0] OP_SET_HP  = 4'h6;
   localparam logic [3:0] OP_RESPAWN = 4'h7;

   localparam logic [7:0] DIR_UP    = 8'd0;
   localparam logic [7:0] DIR_LEFT  = 8'd1;
   localparam logic [7:0] DIR_DOWN  = 8'd2;
   localparam logic [7:0] DIR_RIGHT = 8'd3;

   typedef enum logic [1:0] {
      ST_ALIVE = 2'b00,
      ST_HIT   = 2'b01,
      ST_DEAD  = 2'b10
   } life_state_t;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] ceiling);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, ceiling}) ? ceiling : sum[7:0];
   endfunction

endpackage

// File: rtl/entity_unit_if.sv
// Instruction bus and entity status bundle; the controller is the slave side.
interface entity_unit_if #(parameter int COORD_W = 8);

   logic [15:0]          instruction;
   logic                 instr_valid;
   logic                 move_tick;
   logic [COORD_W-1:0]   pos_x;
   logic [COORD_W-1:0]   pos_y;
   logic [2*COORD_W-1:0] position;
   logic [7:0]           hp;
   logic [7:0]           atk;
   logic [1:0]           life_state;
   logic                 is_death;
   logic                 invuln;

   modport master (
      output instruction, instr_valid, move_tick,
      input  pos_x, pos_y, position, hp, atk, life_state, is_death, invuln
   );

   modport slave (
      input  instruction, instr_valid, move_tick,
      output pos_x, pos_y, position, hp, atk, life_state, is_death, invuln
   );

endinterface

// File: rtl/entity_unit_axis_step_clamp.sv
// One-axis step of SPEED pixels, computed one bit wider and clamped to [LO, HI].
module axis_step_clamp #(
   parameter int COORD_W = 8,
   parameter int SPEED   = 10,
   parameter int LO      = 8,
   parameter int HI      = 192
) (
   input  logic [COORD_W-1:0] coord,
   input  logic               inc,
   input  logic               dec,
   output logic [COORD_W-1:0] next_coord
);

   localparam logic [COORD_W:0] SPEED_W = (COORD_W+1)'(SPEED);
   localparam logic [COORD_W:0] LO_W    = (COORD_W+1)'(LO);
   localparam logic [COORD_W:0] HI_W    = (COORD_W+1)'(HI);

   logic [COORD_W:0] ext;
   logic [COORD_W:0] stepped;
   logic [COORD_W:0] clamped;

   // Decrement floors at zero before clamping so the arena edge never wraps.
   always_comb begin
      ext     = {1'b0, coord};
      stepped = ext;
      clamped = ext;
      if (inc && !dec) begin
         stepped = ext + SPEED_W;
      end else if (dec && !inc) begin
         stepped = (ext >= SPEED_W) ? (ext - SPEED_W) : '0;
      end
      if (stepped < LO_W) begin
         clamped = LO_W;
      end else if (stepped > HI_W) begin
         clamped = HI_W;
      end else begin
         clamped = stepped;
      end
      next_coord = clamped[COORD_W-1:0];
   end

endmodule

// File: rtl/entity_unit.sv
// Game-entity controller: position, HP, ATK and ALIVE/HIT/DEAD life state.
// Optional HP regeneration while ALIVE is built when ENTITY_REGEN_EN is defined.
module entity_unit
   import entity_pkg::*;
#(
   parameter int COORD_W      = 8,
   parameter int ARENA_MIN    = 0,
   parameter int ARENA_MAX    = 200,
   parameter int SIZE         = 16,
   parameter int SPEED        = 10,
   parameter int HP_MAX       = 100,
   parameter int ATK_INIT     = 10,
   parameter int START_X      = 100,
   parameter int START_Y      = 100,
   parameter int IFRAME_TICKS = 5,
   parameter int REGEN_TICKS  = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   entity_unit_if.slave bus
);

   localparam logic [7:0]         HP_MAX8     = 8'(HP_MAX);
   localparam logic [7:0]         ATK_INIT8   = 8'(ATK_INIT);
   localparam logic [7:0]         IFRAME_INIT = 8'(IFRAME_TICKS);
   localparam logic [COORD_W-1:0] START_XC    = COORD_W'(START_X);
   localparam logic [COORD_W-1:0] START_YC    = COORD_W'(START_Y);
   localparam int                 LO_EDGE     = ARENA_MIN + SIZE / 2;
   localparam int                 HI_EDGE     = ARENA_MAX - SIZE / 2;

   life_state_t        state_q, state_d;
   logic [7:0]         hp_q, hp_d;
   logic [7:0]         atk_q, atk_d;
   logic [7:0]         iframe_q, iframe_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0] x_step, y_step;

   logic [3:0] opcode;
   logic [7:0] operand;
   logic       move_go;
   logic       x_inc, x_dec, y_inc, y_dec;
   logic [7:0] dmg_result;
   logic       unused_instr_bits;

   assign opcode            = bus.instruction[15:12];
   assign operand           = bus.instruction[11:4];
   assign unused_instr_bits = ^bus.instruction[3:0];

   assign move_go = bus.instr_valid && bus.move_tick && (opcode == OP_MOVE) &&
                    (state_q != ST_DEAD);
   assign x_inc   = move_go && (operand == DIR_RIGHT);
   assign x_dec   = move_go && (operand == DIR_LEFT);
   assign y_inc   = move_go && (operand == DIR_DOWN);
   assign y_dec   = move_go && (operand == DIR_UP);

   assign dmg_result = (hp_q > operand) ? (hp_q - operand) : 8'd0;

   axis_step_clamp #(.COORD_W(COORD_W), .SPEED(SPEED), .LO(LO_EDGE), .HI(HI_EDGE)) u_step_x (
      .coord(x_q), .inc(x_inc), .dec(x_dec), .next_coord(x_step)
   );

   axis_step_clamp #(.COORD_W(COORD_W), .SPEED(SPEED), .LO(LO_EDGE), .HI(HI_EDGE)) u_step_y (
      .coord(y_q), .inc(y_inc), .dec(y_dec), .next_coord(y_step)
   );

`ifdef ENTITY_REGEN_EN
   localparam logic [7:0] REGEN_LAST = 8'(REGEN_TICKS - 1);
   logic [7:0] regen_q, regen_d;
`endif

   // Tick-driven updates are applied first so an accepted instruction in the
   // same cycle can override them (e.g. set HP 0 while the i-frames expire).
   always_comb begin
      state_d  = state_q;
      hp_d     = hp_q;
      atk_d    = atk_q;
      iframe_d = iframe_q;
      x_d      = x_q;
      y_d      = y_q;
`ifdef ENTITY_REGEN_EN
      regen_d  = regen_q;
`endif

      if (bus.move_tick && (state_q == ST_HIT)) begin
         if (iframe_q <= 8'd1) begin
            iframe_d = '0;
            state_d  = ST_ALIVE;
         end else begin
            iframe_d = iframe_q - 8'd1;
         end
      end

`ifdef ENTITY_REGEN_EN
      if (bus.move_tick && (state_q == ST_ALIVE)) begin
         if (regen_q >= REGEN_LAST) begin
            regen_d = '0;
            hp_d    = sat_add8(hp_q, 8'd1, HP_MAX8);
         end else begin
            regen_d = regen_q + 8'd1;
         end
      end
`endif

      if (bus.instr_valid) begin
         if (state_q == ST_DEAD) begin
            if (opcode == OP_RESPAWN) begin
               hp_d = HP_MAX8;
               x_d  = START_XC;
               y_d  = START_YC;
               if (IFRAME_TICKS > 0) begin
                  state_d  = ST_HIT;
                  iframe_d = IFRAME_INIT;
               end else begin
                  state_d  = ST_ALIVE;
                  iframe_d = '0;
               end
            end
         end else begin
            case (opcode)
               OP_HEAL:    hp_d  = sat_add8(hp_q, operand, HP_MAX8);
               OP_ATK_ADD: atk_d = sat_add8(atk_q, operand, 8'hFF);
               OP_ATK_SET: atk_d = operand;
               OP_MOVE: begin
                  if (x_inc || x_dec) x_d = x_step;
                  if (y_inc || y_dec) y_d = y_step;
               end
               OP_DAMAGE: begin
                  if (state_q == ST_ALIVE) begin
                     hp_d = dmg_result;
`ifdef ENTITY_REGEN_EN
                     regen_d = '0;
`endif
                     if (dmg_result == 8'd0) begin
                        state_d  = ST_DEAD;
                        iframe_d = '0;
                     end else if ((operand != 8'd0) && (IFRAME_TICKS > 0)) begin
                        state_d  = ST_HIT;
                        iframe_d = IFRAME_INIT;
                     end
                  end
               end
               OP_SET_HP: begin
                  hp_d = (operand > HP_MAX8) ? HP_MAX8 : operand;
                  if (operand == 8'd0) begin
                     state_d  = ST_DEAD;
                     iframe_d = '0;
`ifdef ENTITY_REGEN_EN
                     regen_d  = '0;
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_ALIVE;
         hp_q     <= HP_MAX8;
         atk_q    <= ATK_INIT8;
         iframe_q <= '0;
         x_q      <= START_XC;
         y_q      <= START_YC;
      end else begin
         state_q  <= state_d;
         hp_q     <= hp_d;
         atk_q    <= atk_d;
         iframe_q <= iframe_d;
         x_q      <= x_d;
         y_q      <= y_d;
      end
   end

`ifdef ENTITY_REGEN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regen_q <= '0;
      end else begin
         regen_q <= regen_d;
      end
   end
`endif

   assign bus.pos_x      = x_q;
   assign bus.pos_y      = y_q;
   assign bus.position   = {x_q, y_q};
   assign bus.hp         = hp_q;
   assign bus.atk        = atk_q;
   assign bus.life_state = state_q;
   assign bus.is_death   = (state_q == ST_DEAD);
   assign bus.invuln     = (state_q == ST_HIT);

endmodule

// File: tb/tb_entity_unit.sv
// Self-checking bench for entity_unit: vector table plus scoreboard, with
// hand-written async-reset and regeneration sequences.
module tb_entity_unit;

   typedef struct {
      logic [15:0] instr;
      logic        valid;
      logic        tick;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [7:0]  hp;
      logic [7:0]  atk;
      logic [1:0]  st;
   } vec_t;

   localparam logic [1:0] A = 2'b00;
   localparam logic [1:0] H = 2'b01;
   localparam logic [1:0] D = 2'b10;

`ifdef ENTITY_REGEN_EN
   localparam int REGEN_ON = 1;
`else
   localparam int REGEN_ON = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails = 0;
   vec_t sb[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   entity_unit_if #(.COORD_W(8)) bus ();

   entity_unit dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   function automatic vec_t mk(input logic [3:0] op, input logic [7:0] arg,
                               input logic valid, input logic tick,
                               input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] hp, input logic [7:0] atk,
                               input logic [1:0] st);
      vec_t v;
      v.instr = {op, arg, 4'h0};
      v.valid = valid;
      v.tick  = tick;
      v.x     = x;
      v.y     = y;
      v.hp    = hp;
      v.atk   = atk;
      v.st    = st;
      return v;
   endfunction

   task automatic check_output(input string tag);
      vec_t e;
      logic ok;
      checks++;
      if (sb.size() == 0) begin
         fails++;
         $display("[TB] FAIL %s: scoreboard empty, no expected entry available", tag);
         return;
      end
      e  = sb.pop_front();
      ok = (bus.pos_x === e.x) && (bus.pos_y === e.y) && (bus.hp === e.hp) &&
           (bus.atk === e.atk) && (bus.life_state === e.st) &&
           (bus.position === {e.x, e.y}) &&
           (bus.is_death === (e.st == D)) && (bus.invuln === (e.st == H));
      if (!ok) begin
         fails++;
         $display("[TB] FAIL %s: got x=%0d y=%0d pos=%h hp=%0d atk=%0d st=%0d death=%b inv=%b, expected x=%0d y=%0d hp=%0d atk=%0d st=%0d",
                  tag, bus.pos_x, bus.pos_y, bus.position, bus.hp, bus.atk, bus.life_state,
                  bus.is_death, bus.invuln, e.x, e.y, e.hp, e.atk, e.st);
      end
   endtask

   task automatic apply_stimulus(input vec_t v, input string tag);
      @(negedge clk);
      bus.instruction = v.instr;
      bus.instr_valid = v.valid;
      bus.move_tick   = v.tick;
      sb.push_back(v);
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.move_tick   = 1'b0;
      check_output(tag);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] x;
      bus.instruction = '0;
      bus.instr_valid = 1'b0;
      bus.move_tick   = 1'b0;

      // Walk left to the arena edge, then exercise the rest of the opcodes.
      x = 8'd100;
      for (int i = 0; i < 11; i++) begin
         x = (x >= 8'd18) ? x - 8'd10 : 8'd8;
         tbl.push_back(mk(4'h5, 8'd1, 1, 1, x, 100, 100, 10, A));
      end
      tbl.push_back(mk(4'h5, 8'd2,   1, 0,  8, 100, 100,  10, A));
      tbl.push_back(mk(4'h5, 8'd2,   1, 1,  8, 110, 100,  10, A));
      tbl.push_back(mk(4'h5, 8'd7,   1, 1,  8, 110, 100,  10, A));
      tbl.push_back(mk(4'h5, 8'd3,   0, 1,  8, 110, 100,  10, A));
      tbl.push_back(mk(4'h5, 8'd3,   1, 1, 18, 110, 100,  10, A));
      tbl.push_back(mk(4'h5, 8'd0,   1, 1, 18, 100, 100,  10, A));
      tbl.push_back(mk(4'h5, 8'd0,   1, 1, 18,  90, 100,  10, A));
      tbl.push_back(mk(4'h1, 8'd50,  1, 0, 18,  90, 100,  10, A));
      tbl.push_back(mk(4'h3, 8'd250, 1, 0, 18,  90, 100, 255, A));
      tbl.push_back(mk(4'h3, 8'd5,   1, 0, 18,  90, 100, 255, A));
      tbl.push_back(mk(4'h4, 8'd42,  1, 0, 18,  90, 100,  42, A));
      tbl.push_back(mk(4'h6, 8'd200, 1, 0, 18,  90, 100,  42, A));
      tbl.push_back(mk(4'h6, 8'd90,  1, 0, 18,  90,  90,  42, A));
      tbl.push_back(mk(4'h1, 8'd50,  1, 0, 18,  90, 100,  42, A));
      tbl.push_back(mk(4'h0, 8'd99,  1, 0, 18,  90, 100,  42, A));
      tbl.push_back(mk(4'h8, 8'd1,   1, 0, 18,  90, 100,  42, A));
      tbl.push_back(mk(4'h2, 8'd0,   1, 0, 18,  90, 100,  42, A));
      tbl.push_back(mk(4'h2, 8'd30,  1, 0, 18,  90,  70,  42, H));
      tbl.push_back(mk(4'h0, 8'd0,   0, 1, 18,  90,  70,  42, H));
      tbl.push_back(mk(4'h2, 8'd30,  1, 1, 18,  90,  70,  42, H));
      tbl.push_back(mk(4'h1, 8'd5,   1, 1, 18,  90,  75,  42, H));
      tbl.push_back(mk(4'h0, 8'd0,   0, 1, 18,  90,  75,  42, H));
      tbl.push_back(mk(4'h2, 8'd30,  1, 1, 18,  90,  75,  42, A));
      tbl.push_back(mk(4'h2, 8'd30,  1, 0, 18,  90,  45,  42, H));
      tbl.push_back(mk(4'h5, 8'd2,   1, 1, 18, 100,  45,  42, H));
      tbl.push_back(mk(4'h6, 8'd0,   1, 0, 18, 100,   0,  42, D));
      tbl.push_back(mk(4'h1, 8'd50,  1, 0, 18, 100,   0,  42, D));
      tbl.push_back(mk(4'h5, 8'd0,   1, 1, 18, 100,   0,  42, D));
      tbl.push_back(mk(4'h4, 8'd1,   1, 0, 18, 100,   0,  42, D));
      tbl.push_back(mk(4'h6, 8'd50,  1, 0, 18, 100,   0,  42, D));
      tbl.push_back(mk(4'h2, 8'd10,  1, 0, 18, 100,   0,  42, D));
      tbl.push_back(mk(4'h7, 8'd0,   1, 0, 100, 100, 100, 42, H));
      tbl.push_back(mk(4'h7, 8'd0,   1, 0, 100, 100, 100, 42, H));
      tbl.push_back(mk(4'h2, 8'd150, 1, 0, 100, 100, 100, 42, H));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(4'h0, 8'd0, 0, 1, 100, 100, 100, 42, H));
      tbl.push_back(mk(4'h0, 8'd0,   0, 1, 100, 100, 100, 42, A));
      tbl.push_back(mk(4'h2, 8'd150, 1, 0, 100, 100,   0, 42, D));
      tbl.push_back(mk(4'h7, 8'd0,   1, 0, 100, 100, 100, 42, H));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(4'h0, 8'd0, 0, 1, 100, 100, 100, 42, H));
      tbl.push_back(mk(4'h0, 8'd0,   0, 1, 100, 100, 100, 42, A));

      #12;
      sb.push_back(mk(4'h0, 8'd0, 0, 0, 100, 100, 100, 10, A));
      check_output("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply_stimulus(tbl[i], $sformatf("vec%0d", i));
      end

      apply_stimulus(mk(4'h4, 8'd77, 1, 0, 100, 100, 100, 77, A), "atk_set_77");
      apply_stimulus(mk(4'h5, 8'd3,  1, 1, 110, 100, 100, 77, A), "move_right");

      // Reset asserted between clock edges must take effect without a clock.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb.push_back(mk(4'h0, 8'd0, 0, 0, 100, 100, 100, 10, A));
      check_output("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(mk(4'h0, 8'd0, 0, 0, 100, 100, 100, 10, A), "reset_hold");

      apply_stimulus(mk(4'h6, 8'd50, 1, 0, 100, 100, 50, 10, A), "set_hp_50");
      for (int i = 0; i < 40; i++) begin
         apply_stimulus(mk(4'h0, 8'd0, 0, 1, 100, 100, 8'(50 + REGEN_ON * ((i + 1) / 20)), 10, A),
                        $sformatf("regen_tick%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
